// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the stereo de-emphasis IIR scheduler.
package iir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MAC   = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } ch_e;

    localparam int DEFAULT_BITS = 10;

    // Signed divide by 2^bits rounding toward zero (bias negatives before the arithmetic shift).
    function automatic logic signed [63:0] dequantize(input logic signed [63:0] p, input int bits);
        logic signed [63:0] bias;
        bias = (64'sd1 <<< bits) - 64'sd1;
        if (p < 64'sd0) begin
            return (p + bias) >>> bits;
        end else begin
            return p >>> bits;
        end
    endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Shared multiply / dequantize / accumulate datapath with separate feed-forward and feedback accumulators.
module iir_mac_unit
    import iir_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int BITS      = DEFAULT_BITS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_clear,
    input  logic                        i_en,
    input  logic                        i_sel_y,
    input  logic signed [DATA_SIZE-1:0] i_coef,
    input  logic signed [DATA_SIZE-1:0] i_hist,
    output logic signed [DATA_SIZE-1:0] o_acc_x,
    output logic signed [DATA_SIZE-1:0] o_acc_y,
    output logic signed [DATA_SIZE-1:0] o_dq
);

    logic signed [2*DATA_SIZE-1:0] w_prod;
    logic signed [DATA_SIZE-1:0]   w_dq;
    logic signed [DATA_SIZE-1:0]   r_acc_x;
    logic signed [DATA_SIZE-1:0]   r_acc_y;

    assign w_prod  = i_coef * i_hist;
    assign w_dq    = DATA_SIZE'(dequantize(64'(w_prod), BITS));
    assign o_dq    = w_dq;
    assign o_acc_x = r_acc_x;
    assign o_acc_y = r_acc_y;

    // Accumulators wrap on overflow; clear has priority over accumulate.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc_x <= '0;
            r_acc_y <= '0;
        end else if (i_clear) begin
            r_acc_x <= '0;
            r_acc_y <= '0;
        end else if (i_en) begin
            if (i_sel_y) begin
                r_acc_y <= r_acc_y + w_dq;
            end else begin
                r_acc_x <= r_acc_x + w_dq;
            end
        end
    end

endmodule

// File: rtl/iir_stereo_sched.sv
// Round-robin scheduler sharing one IIR MAC datapath between left and right channels.
module iir_stereo_sched
    import iir_pkg::*;
#(
    parameter int TAPS      = 2,
    parameter int DATA_SIZE = 32,
    parameter int BITS      = DEFAULT_BITS,
    parameter logic signed [DATA_SIZE-1:0] X_COEFFS [0:TAPS-1] = '{32'h000000B2, 32'h000000B2},
    parameter logic signed [DATA_SIZE-1:0] Y_COEFFS [0:TAPS-1] = '{32'h00000000, 32'hFFFFFD66}
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 l_in_empty,
    output logic                 l_in_rd_en,
    input  logic [DATA_SIZE-1:0] l_in_dout,
    input  logic                 r_in_empty,
    output logic                 r_in_rd_en,
    input  logic [DATA_SIZE-1:0] r_in_dout,
    input  logic                 l_out_full,
    output logic                 l_out_wr_en,
    output logic [DATA_SIZE-1:0] l_out_din,
    input  logic                 r_out_full,
    output logic                 r_out_wr_en,
    output logic [DATA_SIZE-1:0] r_out_din
);

    localparam int              KW    = $clog2(2*TAPS);
    localparam logic [KW-1:0]   KLAST = KW'(2*TAPS-1);

    state_e                      r_state;
    ch_e                         r_ch;
    ch_e                         r_last;
    logic [KW-1:0]               r_k;
    logic signed [DATA_SIZE-1:0] r_x [0:1][0:TAPS-1];
    logic signed [DATA_SIZE-1:0] r_y [0:1][0:TAPS-1];
    logic                        r_l_in_rd_en, r_r_in_rd_en;
    logic                        r_l_out_wr_en, r_r_out_wr_en;
    logic [DATA_SIZE-1:0]        r_l_out_din, r_r_out_din;

    logic                        w_l_elig, w_r_elig;
    ch_e                         w_grant;
    logic signed [DATA_SIZE-1:0] w_in_dout;
    logic signed [DATA_SIZE-1:0] w_coef, w_hist;
    logic                        w_sel_y;
    logic signed [DATA_SIZE-1:0] w_acc_x, w_acc_y, w_dq, w_res;

    assign l_in_rd_en  = r_l_in_rd_en;
    assign r_in_rd_en  = r_r_in_rd_en;
    assign l_out_wr_en = r_l_out_wr_en;
    assign r_out_wr_en = r_r_out_wr_en;
    assign l_out_din   = r_l_out_din;
    assign r_out_din   = r_r_out_din;

    assign w_in_dout = (r_ch == CH_L) ? l_in_dout : r_in_dout;
    // Final feedback product is still in flight on the last MAC cycle, so fold it in here.
    assign w_res     = w_acc_x + w_acc_y + w_dq;

    // Eligibility and round-robin grant; a tie goes to the channel not served last.
    always_comb begin
        w_l_elig = !l_in_empty && !l_out_full;
        w_r_elig = !r_in_empty && !r_out_full;
        if (w_l_elig && w_r_elig) begin
            w_grant = (r_last == CH_L) ? CH_R : CH_L;
        end else if (w_l_elig) begin
            w_grant = CH_L;
        end else begin
            w_grant = CH_R;
        end
    end

    // MAC operand select: k<TAPS walks the X history newest-first, then the Y history.
    always_comb begin
        w_coef  = '0;
        w_hist  = '0;
        w_sel_y = (r_k >= KW'(TAPS));
        for (int i = 0; i < TAPS; i++) begin
            if (r_k == KW'(i)) begin
                w_coef = X_COEFFS[i];
                w_hist = r_x[r_ch][TAPS-1-i];
            end else if (r_k == KW'(i + TAPS)) begin
                w_coef = Y_COEFFS[i];
                w_hist = r_y[r_ch][TAPS-1-i];
            end else begin
            end
        end
    end

    iir_mac_unit #(
        .DATA_SIZE (DATA_SIZE),
        .BITS      (BITS)
    ) u_mac (
        .clock   (clock),
        .reset   (reset),
        .i_clear (r_state == ST_LOAD),
        .i_en    (r_state == ST_MAC),
        .i_sel_y (w_sel_y),
        .i_coef  (w_coef),
        .i_hist  (w_hist),
        .o_acc_x (w_acc_x),
        .o_acc_y (w_acc_y),
        .o_dq    (w_dq)
    );

    // Scheduler FSM, per-channel history and registered FIFO strobes/data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ch          <= CH_L;
            r_last        <= CH_R;
            r_k           <= '0;
            r_l_in_rd_en  <= 1'b0;
            r_r_in_rd_en  <= 1'b0;
            r_l_out_wr_en <= 1'b0;
            r_r_out_wr_en <= 1'b0;
            r_l_out_din   <= '0;
            r_r_out_din   <= '0;
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < TAPS; i++) begin
                    r_x[c][i] <= '0;
                    r_y[c][i] <= '0;
                end
            end
        end else begin
            r_l_in_rd_en  <= 1'b0;
            r_r_in_rd_en  <= 1'b0;
            r_l_out_wr_en <= 1'b0;
            r_r_out_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_l_elig || w_r_elig) begin
                        r_ch         <= w_grant;
                        r_last       <= w_grant;
                        r_l_in_rd_en <= (w_grant == CH_L);
                        r_r_in_rd_en <= (w_grant == CH_R);
                        r_state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    for (int i = 0; i < TAPS-1; i++) begin
                        r_x[r_ch][i] <= r_x[r_ch][i+1];
                        r_y[r_ch][i] <= r_y[r_ch][i+1];
                    end
                    r_x[r_ch][TAPS-1] <= w_in_dout;
                    r_k               <= '0;
                    r_state           <= ST_MAC;
                end
                ST_MAC: begin
                    r_k <= r_k + KW'(1);
                    if (r_k == KLAST) begin
                        r_y[r_ch][TAPS-1] <= w_res;
                        if (r_ch == CH_L) begin
                            r_l_out_din   <= w_res;
                            r_l_out_wr_en <= 1'b1;
                        end else begin
                            r_r_out_din   <= w_res;
                            r_r_out_wr_en <= 1'b1;
                        end
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
